// File: rtl/reflet_pwm_capture.sv
// Reflet bus peripheral measuring period and high time of an external PWM-like input.
// Four byte registers: CTRL, STATUS, PERIOD, HIGH; level-sensitive interrupt on a fresh capture.
module reflet_pwm_capture #(
  parameter int                        base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr      = 16'hFF1C
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  input  logic                      write_en,
  input  logic                      in,
  output logic                      irq
);

  localparam int SYNC_STAGES = 2;

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_PERIOD = 2'd2;
  localparam logic [1:0] OFF_HIGH   = 2'd3;

  // Bus decode: the difference form avoids overflowing base_addr+4 near the top of the map.
  logic [base_addr_size-1:0] addr_diff;
  logic                      sel;
  logic [1:0]                offset;
  logic                      bus_wr;
  logic                      unused_data;

  assign addr_diff   = addr - base_addr;
  assign sel         = enable && (addr_diff[base_addr_size-1:2] == '0);
  assign offset      = addr_diff[1:0];
  assign bus_wr      = sel && write_en;
  assign unused_data = ^data_in[7:3];

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_chain_in;
  logic                   s_d_reg;
  logic                   level;
  logic                   rise;
  logic                   fall;

  assign sync_chain_in = {sync_reg[SYNC_STAGES-2:0], in};

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (!reset) begin
          sync_reg[gi] <= 1'b0;
        end else begin
          sync_reg[gi] <= sync_chain_in[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      s_d_reg <= 1'b0;
    end else begin
      s_d_reg <= level;
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = level & ~s_d_reg;
  assign fall  = ~level & s_d_reg;

  logic       run_reg, run_next;
  logic       oneshot_reg, oneshot_next;
  logic       irq_en_reg, irq_en_next;
  logic       valid_reg, valid_next;
  logic       ovf_reg, ovf_next;
  logic [7:0] period_reg, period_next;
  logic [7:0] high_reg, high_next;
  logic [1:0] state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [7:0] hcnt_reg, hcnt_next;
  logic       hfrozen_reg, hfrozen_next;
  logic       irq_reg, irq_next;

  always_comb begin
    run_next     = run_reg;
    oneshot_next = oneshot_reg;
    irq_en_next  = irq_en_reg;
    valid_next   = valid_reg;
    ovf_next     = ovf_reg;
    period_next  = period_reg;
    high_next    = high_reg;
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hcnt_next    = hcnt_reg;
    hfrozen_next = hfrozen_reg;

    // Bus writes first so that hardware set events below take priority over W1C.
    if (bus_wr && offset == OFF_CTRL) begin
      run_next     = data_in[0];
      oneshot_next = data_in[1];
      irq_en_next  = data_in[2];
    end
    if (bus_wr && offset == OFF_STATUS) begin
      if (data_in[0]) valid_next = 1'b0;
      if (data_in[1]) ovf_next   = 1'b0;
    end

    case (state_reg)
      ST_OFF: begin
        if (run_reg) begin
          state_next = ST_ARM;
        end
      end
      ST_ARM: begin
        if (rise) begin
          cnt_next     = 8'd1;
          hcnt_next    = 8'd1;
          hfrozen_next = 1'b0;
          state_next   = ST_MEAS;
        end
      end
      ST_MEAS: begin
        if (rise) begin
          period_next  = cnt_reg;
          high_next    = hcnt_reg;
          valid_next   = 1'b1;
          cnt_next     = 8'd1;
          hcnt_next    = 8'd1;
          hfrozen_next = 1'b0;
          if (oneshot_reg) begin
            run_next = 1'b0;
          end
        end else if (cnt_reg == 8'hFF) begin
          // Period exceeds the 8-bit range: flag it and wait for a fresh edge.
          ovf_next     = 1'b1;
          cnt_next     = 8'd0;
          hcnt_next    = 8'd0;
          hfrozen_next = 1'b0;
          state_next   = ST_ARM;
        end else begin
          cnt_next = cnt_reg + 8'd1;
          if (fall) begin
            hfrozen_next = 1'b1;
          end else if (!hfrozen_reg) begin
            hcnt_next = hcnt_reg + 8'd1;
          end
        end
      end
      default: begin
        state_next = ST_OFF;
      end
    endcase

    // Clearing run (by the bus or by a oneshot capture) parks the block with idle counters.
    if (!run_next) begin
      state_next   = ST_OFF;
      cnt_next     = 8'd0;
      hcnt_next    = 8'd0;
      hfrozen_next = 1'b0;
    end
  end

  assign irq_next = irq_en_reg & valid_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_reg     <= 1'b0;
      oneshot_reg <= 1'b0;
      irq_en_reg  <= 1'b0;
      valid_reg   <= 1'b0;
      ovf_reg     <= 1'b0;
      period_reg  <= 8'd0;
      high_reg    <= 8'd0;
      state_reg   <= ST_OFF;
      cnt_reg     <= 8'd0;
      hcnt_reg    <= 8'd0;
      hfrozen_reg <= 1'b0;
      irq_reg     <= 1'b0;
    end else begin
      run_reg     <= run_next;
      oneshot_reg <= oneshot_next;
      irq_en_reg  <= irq_en_next;
      valid_reg   <= valid_next;
      ovf_reg     <= ovf_next;
      period_reg  <= period_next;
      high_reg    <= high_next;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hcnt_reg    <= hcnt_next;
      hfrozen_reg <= hfrozen_next;
      irq_reg     <= irq_next;
    end
  end

  assign irq = irq_reg;

  always_comb begin
    data_out = 8'h00;
    if (sel) begin
      case (offset)
        OFF_CTRL:   data_out = {5'b0, irq_en_reg, oneshot_reg, run_reg};
        OFF_STATUS: data_out = {5'b0, level, ovf_reg, valid_reg};
        OFF_PERIOD: data_out = period_reg;
        OFF_HIGH:   data_out = high_reg;
        default:    data_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_pwm_capture.sv
// Scoreboard bench for reflet_pwm_capture: stimulus pushes expected reads, a negedge monitor checks them.
module tb_reflet_pwm_capture;

  localparam logic [15:0] BASE = 16'hFF1C;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        write_en;
  logic        in_sig = 1'b0;
  logic        irq;

  reflet_pwm_capture #(.base_addr_size(16), .base_addr(BASE)) dut (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr), .data_in(data_in),
    .data_out(data_out), .write_en(write_en), .in(in_sig), .irq(irq)
  );

  always #5 clk = ~clk;

  // kind 0: data_out, kind 1: irq, kind 2: bench timeout flag
  typedef struct {
    string      name;
    logic [7:0] exp;
    logic [7:0] mask;
    logic [1:0] kind;
  } sb_t;

  sb_t  sb[$];
  logic chk_req  = 1'b0;
  logic tmo_flag = 1'b0;
  int   total    = 0;
  int   bad      = 0;

  always @(negedge clk) begin
    if (chk_req) begin
      sb_t        e;
      logic [7:0] act;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty: got data_out=%02h required an expected entry", data_out);
      end else begin
        e = sb.pop_front();
        case (e.kind)
          2'd1:    act = {7'b0, irq};
          2'd2:    act = {7'b0, tmo_flag};
          default: act = data_out;
        endcase
        if ((act & e.mask) !== (e.exp & e.mask)) begin
          bad++;
          $display("FAIL %s: got %02h required %02h (mask %02h)", e.name, act, e.exp, e.mask);
        end else begin
          $display("ok   %s: %02h", e.name, act & e.mask);
        end
      end
    end
  end

  // PWM source: high for pwm_h of every pwm_p cycles, or a constant level.
  logic pwm_mode  = 1'b0;
  logic pwm_const = 1'b0;
  int   pwm_p     = 2;
  int   pwm_h     = 1;
  int   pwm_seq   = 0;
  int   seen_seq  = 0;
  int   ph        = 0;
  logic rise_flag = 1'b0;

  always begin
    @(posedge clk);
    #1;
    rise_flag = 1'b0;
    if (pwm_seq != seen_seq) begin
      seen_seq = pwm_seq;
      ph = 0;
    end
    if (pwm_mode) begin
      in_sig    = (ph < pwm_h);
      rise_flag = (ph == 0);
      ph        = (ph == pwm_p - 1) ? 0 : ph + 1;
    end else begin
      in_sig = pwm_const;
    end
  end

  task automatic set_pwm(input logic mode, input int p, input int h, input logic c);
    @(negedge clk);
    pwm_mode  = mode;
    pwm_p     = p;
    pwm_h     = h;
    pwm_const = c;
    pwm_seq++;
  endtask

  task automatic push_chk(input string nm, input logic [7:0] exp, input logic [7:0] mask,
                          input logic [1:0] kind);
    sb_t e;
    e.name = nm;
    e.exp  = exp;
    e.mask = mask;
    e.kind = kind;
    sb.push_back(e);
    chk_req = 1'b1;
    @(posedge clk);
    #1 chk_req = 1'b0;
  endtask

  task automatic rd_addr(input logic en, input logic [15:0] a, input logic [7:0] exp,
                         input logic [7:0] mask, input string nm);
    @(posedge clk);
    #1 enable = en;
    addr     = a;
    write_en = 1'b0;
    push_chk(nm, exp, mask, 2'd0);
    enable = 1'b0;
  endtask

  task automatic rd(input logic [1:0] off, input logic [7:0] exp, input logic [7:0] mask,
                    input string nm);
    rd_addr(1'b1, BASE + 16'(off), exp, mask, nm);
  endtask

  task automatic chk_irq(input logic exp, input string nm);
    @(posedge clk);
    #1 push_chk(nm, {7'b0, exp}, 8'h01, 2'd1);
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] d);
    @(posedge clk);
    #1 enable = 1'b1;
    addr     = BASE + 16'(off);
    data_in  = d;
    write_en = 1'b1;
    @(posedge clk);
    #1 write_en = 1'b0;
    enable = 1'b0;
    $display("wr   off=%0d data=%02h", off, d);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; enable = 1'b0; addr = '0; data_in = '0; write_en = 1'b0;
    wait_cycles(4);
    #1 reset = 1'b1;

    // Reset state
    rd(2'd0, 8'h00, 8'hFF, "rst_ctrl");
    rd(2'd1, 8'h00, 8'hFF, "rst_status");
    rd(2'd2, 8'h00, 8'hFF, "rst_period");
    rd(2'd3, 8'h00, 8'hFF, "rst_high");
    chk_irq(1'b0, "rst_irq");

    // 10 high / 30 low
    set_pwm(1'b1, 40, 10, 1'b0);
    wr(2'd0, 8'h01);
    wait_cycles(130);
    rd(2'd2, 8'h28, 8'hFF, "p40_period");
    rd(2'd3, 8'h0A, 8'hFF, "p40_high");
    rd(2'd1, 8'h01, 8'h03, "p40_valid");
    rd(2'd0, 8'h01, 8'hFF, "p40_ctrl");
    rd_addr(1'b0, BASE + 16'd2, 8'h00, 8'hFF, "en0_read");
    rd_addr(1'b1, BASE + 16'd4, 8'h00, 8'hFF, "out_of_range_hi");
    rd_addr(1'b1, BASE - 16'd1, 8'h00, 8'hFF, "out_of_range_lo");
    wait_cycles(80);
    rd(2'd2, 8'h28, 8'hFF, "p40_period_stable");
    rd(2'd3, 8'h0A, 8'hFF, "p40_high_stable");

    // Oneshot with interrupt
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h03);
    rd(2'd1, 8'h00, 8'h03, "cleared_status");
    wr(2'd0, 8'h07);
    wait_cycles(130);
    rd(2'd0, 8'h06, 8'hFF, "oneshot_ctrl");
    rd(2'd2, 8'h28, 8'hFF, "oneshot_period");
    rd(2'd3, 8'h0A, 8'hFF, "oneshot_high");
    rd(2'd1, 8'h01, 8'h03, "oneshot_valid");
    chk_irq(1'b1, "oneshot_irq");
    wr(2'd1, 8'h01);
    chk_irq(1'b0, "w1c_irq");
    rd(2'd1, 8'h00, 8'h03, "w1c_valid");
    wait_cycles(100);
    rd(2'd1, 8'h00, 8'h03, "oneshot_single_capture");

    // Overflow: one rise, then held high
    wr(2'd0, 8'h00);
    set_pwm(1'b0, 2, 1, 1'b0);
    wait_cycles(5);
    wr(2'd1, 8'h03);
    wr(2'd0, 8'h01);
    wait_cycles(5);
    set_pwm(1'b0, 2, 1, 1'b1);
    wait_cycles(300);
    rd(2'd1, 8'h06, 8'h07, "ovf_status");
    rd(2'd2, 8'h28, 8'hFF, "ovf_period_kept");
    rd(2'd3, 8'h0A, 8'hFF, "ovf_high_kept");

    // Recovery with 20 high / 50 low-and-high
    set_pwm(1'b1, 50, 20, 1'b0);
    wait_cycles(200);
    rd(2'd2, 8'h32, 8'hFF, "rec_period");
    rd(2'd3, 8'h14, 8'hFF, "rec_high");
    rd(2'd1, 8'h03, 8'h03, "rec_status");

    // W1C of valid landing on the capture edge: set must win
    n = 0;
    do begin
      @(posedge clk);
      #2 n++;
    end while (!rise_flag && n < 200);
    tmo_flag = !rise_flag;
    @(posedge clk);
    @(posedge clk);
    #1 enable = 1'b1;
    addr     = BASE + 16'd1;
    data_in  = 8'h01;
    write_en = 1'b1;
    @(posedge clk);
    #1 write_en = 1'b0;
    enable = 1'b0;
    $display("wr   off=1 data=01 (on capture edge)");
    push_chk("rise_wait_timeout", 8'h00, 8'h01, 2'd2);
    rd(2'd1, 8'h01, 8'h01, "w1c_vs_capture");
    wr(2'd2, 8'hFF);
    rd(2'd2, 8'h32, 8'hFF, "period_ro");

    // Boundaries
    wr(2'd0, 8'h00);
    set_pwm(1'b1, 2, 1, 1'b0);
    wr(2'd0, 8'h01);
    wait_cycles(20);
    rd(2'd2, 8'h02, 8'hFF, "p2_period");
    rd(2'd3, 8'h01, 8'hFF, "p2_high");

    wr(2'd0, 8'h00);
    wr(2'd1, 8'h03);
    set_pwm(1'b1, 255, 254, 1'b0);
    wr(2'd0, 8'h01);
    wait_cycles(800);
    rd(2'd2, 8'hFF, 8'hFF, "p255_period");
    rd(2'd3, 8'hFE, 8'hFF, "p255_high");
    rd(2'd1, 8'h01, 8'h03, "p255_no_ovf");

    // Reset in the middle of a measurement
    @(posedge clk);
    #1 reset = 1'b0;
    wait_cycles(2);
    #1 reset = 1'b1;
    rd(2'd0, 8'h00, 8'hFF, "mid_rst_ctrl");
    rd(2'd1, 8'h00, 8'h03, "mid_rst_status");
    rd(2'd2, 8'h00, 8'hFF, "mid_rst_period");
    rd(2'd3, 8'h00, 8'hFF, "mid_rst_high");
    chk_irq(1'b0, "mid_rst_irq");

    wait_cycles(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
